isif_pixel_unpacker: RTL and testbench
======================================

// Module: isif_pixel_unpacker
// PURPOSE
//  Consumer stage directly downstream of the AXI4-Stream input interface FIFO (isif_* read port).
//  Pops one TBITS-wide word at a time and serialises its byte-lanes into one 8-bit pixel per cycle.
//  The output is a valid/ready pixel stream feeding the Sobel window/line-buffer stage.
//  Honours TKEEP (isif_strb_dout), maps TUSER to start-of-frame and TLAST to end-of-line,
//  and tracks the pixel column.
// PARAMETERS
//  TBITS  32  stream word width; must equal 8*TBYTE
//  TBYTE  4   byte lanes per word (strobe width)
//  XBITS  12  width of column counter pix_x
// PORTS
//  ACLK            in   1      clock
//  ARESETN         in   1      reset, synchronous, active-low
//  isif_data_dout  in   TBITS  FIFO head word (first-word-fall-through, valid when isif_empty_n=1)
//  isif_strb_dout  in   TBYTE  FIFO head byte strobes, bit i qualifies bits [8i+7:8i]
//  isif_last_dout  in   1      FIFO head TLAST
//  isif_user_dout  in   1      FIFO head TUSER
//  isif_empty_n    in   1      FIFO not empty
//  isif_read       out  1      pop FIFO head this cycle
//  pix_data        out  8      current pixel
//  pix_valid       out  1      pix_data/pix_sof/pix_eol/pix_x valid
//  pix_ready       in   1      downstream accepts pixel
//  pix_sof         out  1      first pixel of a TUSER=1 word
//  pix_eol         out  1      last kept pixel of a TLAST=1 word
//  pix_x           out  XBITS  column index of current pixel
//  drop_cnt        out  16     saturating count of discarded all-zero-strobe words
// BEHAVIOUR
//  - One clock, ACLK. Reset (ARESETN=0 sampled at posedge) clears the following:
//    word register, mask=0, pix_valid=0, pix_x=0, drop_cnt=0, sof_pend=0.
//  - isif_read is forced 0 while ARESETN=0.
//  - Reset mid-word discards the remaining bytes. The next word starts from byte 0.
//  - Internal state: word reg, mask[TBYTE-1:0] of unsent lanes, last/user flags. pix_valid = |mask.
//  - Current lane = lowest set bit of mask. pix_data is that lane of the word reg.
//  - Output side is a combinational decode of registers only.
//  - hs  = pix_valid & pix_ready
//  - done = ~pix_valid | (hs & mask has exactly one bit set)
//  - isif_read = isif_empty_n & done & ARESETN (combinational). Never asserted when isif_empty_n=0.
//  - On isif_read: word reg <= data, mask <= strb, last/user captured.
//    Latency: FIFO head present with unpacker idle -> pix_valid 1 cycle later.
//  - Back-to-back words: the last-lane handshake and the next pop occur in the same cycle,
//    giving zero bubble (1 pixel/cycle sustained).
//  - On hs that clears the last bit while isif_empty_n=0: pix_valid=0 the next cycle.
//  - Popped word with strb==0:
//    - mask stays 0, so no pixel is emitted and it is effectively consumed in one cycle.
//    - Its last/user flags are dropped.
//    - drop_cnt increments, saturating at 16'hFFFF.
//  - pix_sof = user flag & (current lane is the first kept lane of the word).
//  - pix_eol = last flag & (mask has exactly one bit set).
//  - pix_x:
//    - On hs with pix_eol: pix_x <= 0.
//    - Otherwise on hs: pix_x <= pix_x+1, wrapping modulo 2^XBITS.
//    - On capture of a user=1 word: pix_x <= 0 (sof wins).
//  - While pix_valid & ~pix_ready: pix_data, pix_sof, pix_eol and pix_x hold stable, and isif_read=0.
//  - Lane order: lane 0 (bits 7:0) is emitted first, ascending.
// TESTING
//  1. Word 0x44332211, strb F, user=1, last=0, pix_ready=1
//     -> pixels 11,22,33,44 on 4 consecutive cycles; pix_sof only on 11; pix_x 0..3; one isif_read pulse.
//  2. Word 0xDDCCBBAA, strb 4'b1010, last=1
//     -> pixels BB then DD; pix_eol on DD only; pix_x returns to 0 after the DD handshake.
//  3. Word with strb 0 followed by word 0x04030201 strb F
//     -> no pixel from the first word; drop_cnt=1; pixels 01..04 follow with one idle cycle.
//  4. pix_ready low for 3 cycles while pixel 22 is presented
//     -> pix_data=22 held; isif_read=0 throughout; 33 follows after pix_ready rises.
//  5. Four full words queued, pix_ready=1
//     -> 16 pixels in 16 consecutive cycles; isif_read pulses every 4th cycle; no bubble.
//  6. ARESETN low for 1 cycle after 2 of 4 pixels sent
//     -> pix_valid=0 and drop_cnt=0 next cycle; remaining 2 lanes discarded; next word starts at lane 0.

Source files
------------

// File: rtl/isif_pixel_unpacker.sv
// Pops words from the input-interface FIFO and serialises their kept byte lanes
// into an 8-bit valid/ready pixel stream with start-of-frame, end-of-line and column tags.
module isif_pixel_unpacker #(
    parameter int TBITS = 32,
    parameter int TBYTE = 4,
    parameter int XBITS = 12
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [TBITS-1:0] isif_data_dout,
    input  logic [TBYTE-1:0] isif_strb_dout,
    input  logic             isif_last_dout,
    input  logic             isif_user_dout,
    input  logic             isif_empty_n,
    output logic             isif_read,
    output logic [7:0]       pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic [XBITS-1:0] pix_x,
    output logic [15:0]      drop_cnt
);

    // Handshake: a pixel transfers on a cycle where pix_valid & pix_ready are both 1;
    // pix_valid never drops and the pixel never changes while waiting for pix_ready.

    logic [TBITS-1:0] word_q;
    logic [TBYTE-1:0] mask_q;
    logic             last_q;
    logic             sof_pend;
    logic [TBYTE-1:0] lane_oh;
    logic             single;
    logic             hs;
    logic             done;
    logic             strb_any;

    // Isolate the lowest unsent lane; lanes leave in ascending order.
    assign lane_oh   = mask_q & (~mask_q + TBYTE'(1));
    assign single    = (mask_q != '0) && ((mask_q & (mask_q - TBYTE'(1))) == '0);
    assign pix_valid = |mask_q;
    assign hs        = pix_valid & pix_ready;
    assign done      = ~pix_valid | (hs & single);
    assign isif_read = isif_empty_n & done & ARESETN;
    assign pix_sof   = sof_pend & pix_valid;
    assign pix_eol   = last_q & single;
    assign strb_any  = |isif_strb_dout;

    always_comb begin
        pix_data = '0;
        for (int i = 0; i < TBYTE; i++) begin
            if (lane_oh[i]) begin
                pix_data = word_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            word_q   <= '0;
            mask_q   <= '0;
            last_q   <= 1'b0;
            sof_pend <= 1'b0;
            pix_x    <= '0;
            drop_cnt <= '0;
        end else begin
            if (hs) begin
                pix_x <= pix_eol ? '0 : pix_x + XBITS'(1);
            end
            if (isif_read) begin
                word_q   <= isif_data_dout;
                mask_q   <= isif_strb_dout;
                // An empty word carries no pixel, so its frame/line flags are dropped.
                last_q   <= isif_last_dout & strb_any;
                sof_pend <= isif_user_dout & strb_any;
                if (isif_user_dout && strb_any) begin
                    pix_x <= '0;
                end
                if (!strb_any && drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (hs) begin
                mask_q   <= mask_q & ~lane_oh;
                sof_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isif_pixel_unpacker.sv
// Bench for isif_pixel_unpacker: a FIFO model feeds words, a queue model predicts the
// pixel stream, and directed tests pin the model with hand-computed literals.
module tb_isif_pixel_unpacker;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        user;
    } word_t;

    typedef struct packed {
        logic [7:0]  data;
        logic        sof;
        logic        eol;
        logic [11:0] x;
    } pix_t;

    typedef struct packed {
        logic [31:0] cyc;
        pix_t        p;
    } acc_t;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] isif_data_dout = '0;
    logic [3:0]  isif_strb_dout = '0;
    logic        isif_last_dout = 1'b0;
    logic        isif_user_dout = 1'b0;
    logic        isif_empty_n = 1'b0;
    logic        isif_read;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_sof;
    logic        pix_eol;
    logic [11:0] pix_x;
    logic [15:0] drop_cnt;

    isif_pixel_unpacker #(.TBITS(32), .TBYTE(4), .XBITS(12)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .isif_data_dout(isif_data_dout), .isif_strb_dout(isif_strb_dout),
        .isif_last_dout(isif_last_dout), .isif_user_dout(isif_user_dout),
        .isif_empty_n(isif_empty_n), .isif_read(isif_read),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_x(pix_x), .drop_cnt(drop_cnt)
    );

    always #5 ACLK = ~ACLK;

    int          n_chk = 0;
    int          n_pass = 0;
    logic        chk_en = 1'b0;
    logic        pop_now = 1'b0;
    logic [31:0] cyc = 0;
    word_t       fifo_q[$];
    pix_t        exp_q[$];
    acc_t        acc_log[$];
    logic [31:0] rd_log[$];
    logic [11:0] col = '0;
    logic [15:0] exp_drop = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Expected pixels of one popped word, from the stream rules alone.
    task automatic model_word(input word_t w);
        int   hi;
        logic first;
        pix_t p;
        hi = 0;
        first = 1'b1;
        if (w.strb == 4'b0) begin
            if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        end else begin
            for (int i = 0; i < 4; i++) if (w.strb[i]) hi = i;
            if (w.user) col = '0;
            for (int i = 0; i < 4; i++) begin
                if (w.strb[i]) begin
                    p.data = w.data[8*i +: 8];
                    p.sof  = w.user && first;
                    p.eol  = w.last && (i == hi);
                    p.x    = col;
                    exp_q.push_back(p);
                    col   = p.eol ? 12'd0 : col + 12'd1;
                    first = 1'b0;
                end
            end
        end
    endtask

    // Compare process: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge ACLK) begin
        logic hs;
        logic exp_rd;
        acc_t a;
        cyc = cyc + 1;
        if (chk_en) begin
            hs = pix_valid && pix_ready;
            exp_rd = isif_empty_n && ARESETN &&
                     (exp_q.size() == 0 || (hs && exp_q.size() == 1));
            check("pix_valid", 32'(pix_valid), 32'(exp_q.size() != 0));
            check("isif_read", 32'(isif_read), 32'(exp_rd));
            check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
            if (pix_valid && exp_q.size() != 0) begin
                check("pix_data", 32'(pix_data), 32'(exp_q[0].data));
                check("pix_sof", 32'(pix_sof), 32'(exp_q[0].sof));
                check("pix_eol", 32'(pix_eol), 32'(exp_q[0].eol));
                check("pix_x", 32'(pix_x), 32'(exp_q[0].x));
            end
            if (!ARESETN) begin
                exp_q.delete();
                col = '0;
                exp_drop = '0;
            end else begin
                if (hs && exp_q.size() != 0) begin
                    a.cyc = cyc;
                    a.p = exp_q.pop_front();
                    acc_log.push_back(a);
                end
                if (isif_read && fifo_q.size() != 0) begin
                    rd_log.push_back(cyc);
                    model_word(fifo_q[0]);
                end
            end
        end
        pop_now = isif_read;
    end

    task automatic drive();
        if (fifo_q.size() != 0) begin
            isif_empty_n   = 1'b1;
            isif_data_dout = fifo_q[0].data;
            isif_strb_dout = fifo_q[0].strb;
            isif_last_dout = fifo_q[0].last;
            isif_user_dout = fifo_q[0].user;
        end else begin
            isif_empty_n   = 1'b0;
            isif_data_dout = '0;
            isif_strb_dout = '0;
            isif_last_dout = 1'b0;
            isif_user_dout = 1'b0;
        end
    endtask

    task automatic cycle();
        drive();
        @(posedge ACLK);
        #1;
        if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l, input logic u);
        word_t w;
        w.data = d; w.strb = s; w.last = l; w.user = u;
        fifo_q.push_back(w);
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(fifo_q.size() + exp_q.size()), 32'd0);
        repeat (2) cycle();
    endtask

    task automatic start_test();
        acc_log.delete();
        rd_log.delete();
    endtask

    initial begin
        logic [31:0] t0;
        logic [31:0] a;
        // Reset
        ARESETN = 1'b0;
        cycle();
        chk_en = 1'b1;
        cycle();
        cycle();
        ARESETN = 1'b1;
        #1;
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_x", 32'(pix_x), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // 1: full word, start of frame
        start_test();
        t0 = cyc;
        push(32'h44332211, 4'hF, 1'b0, 1'b1);
        run_idle(20);
        check("t1_count", 32'(acc_log.size()), 32'd4);
        check("t1_reads", 32'(rd_log.size()), 32'd1);
        if (acc_log.size() == 4) begin
            check("t1_latency", acc_log[0].cyc, t0 + 2);
            check("t1_d0", 32'(acc_log[0].p.data), 32'h11);
            check("t1_d1", 32'(acc_log[1].p.data), 32'h22);
            check("t1_d2", 32'(acc_log[2].p.data), 32'h33);
            check("t1_d3", 32'(acc_log[3].p.data), 32'h44);
            check("t1_sof0", 32'(acc_log[0].p.sof), 32'd1);
            check("t1_sof1", 32'(acc_log[1].p.sof), 32'd0);
            check("t1_x3", 32'(acc_log[3].p.x), 32'd3);
            check("t1_consec", acc_log[3].cyc, acc_log[0].cyc + 3);
        end

        // 2: sparse strobes, end of line
        start_test();
        push(32'hDDCCBBAA, 4'b1010, 1'b1, 1'b0);
        run_idle(20);
        check("t2_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() == 2) begin
            check("t2_d0", 32'(acc_log[0].p.data), 32'hBB);
            check("t2_d1", 32'(acc_log[1].p.data), 32'hDD);
            check("t2_eol0", 32'(acc_log[0].p.eol), 32'd0);
            check("t2_eol1", 32'(acc_log[1].p.eol), 32'd1);
            check("t2_x0", 32'(acc_log[0].p.x), 32'd4);
            check("t2_x1", 32'(acc_log[1].p.x), 32'd5);
        end
        check("t2_x_after", 32'(pix_x), 32'd0);

        // 3: empty-strobe word dropped, then a full word
        start_test();
        t0 = cyc;
        push(32'hEEEEEEEE, 4'b0000, 1'b1, 1'b1);
        push(32'h04030201, 4'hF, 1'b0, 1'b0);
        run_idle(20);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        check("t3_count", 32'(acc_log.size()), 32'd4);
        if (acc_log.size() == 4) begin
            check("t3_gap", acc_log[0].cyc, t0 + 3);
            check("t3_d0", 32'(acc_log[0].p.data), 32'h01);
            check("t3_d3", 32'(acc_log[3].p.data), 32'h04);
            check("t3_sof0", 32'(acc_log[0].p.sof), 32'd0);
            check("t3_x3", 32'(acc_log[3].p.x), 32'd3);
        end

        // 4: backpressure while 22 is presented, next word waiting
        start_test();
        push(32'h44332211, 4'hF, 1'b0, 1'b0);
        cycle();
        cycle();
        push(32'h88776655, 4'hF, 1'b0, 1'b0);
        pix_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_hold_data", 32'(pix_data), 32'h22);
            check("t4_hold_read", 32'(isif_read), 32'd0);
            cycle();
        end
        pix_ready = 1'b1;
        run_idle(30);
        check("t4_count", 32'(acc_log.size()), 32'd8);
        if (acc_log.size() == 8) begin
            check("t4_d1", 32'(acc_log[1].p.data), 32'h22);
            check("t4_stall", acc_log[1].cyc, acc_log[0].cyc + 4);
            check("t4_d2", 32'(acc_log[2].p.data), 32'h33);
            check("t4_resume", acc_log[2].cyc, acc_log[1].cyc + 1);
            check("t4_d4", 32'(acc_log[4].p.data), 32'h55);
            check("t4_nobubble", acc_log[4].cyc, acc_log[3].cyc + 1);
        end

        // 5: four queued words stream without bubbles
        start_test();
        for (int k = 0; k < 4; k++) begin
            a = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            push(a, 4'hF, 1'b0, 1'b0);
        end
        run_idle(40);
        check("t5_count", 32'(acc_log.size()), 32'd16);
        check("t5_reads", 32'(rd_log.size()), 32'd4);
        if (acc_log.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("t5_data", 32'(acc_log[i].p.data), 32'(i));
                check("t5_cyc", acc_log[i].cyc, acc_log[0].cyc + 32'(i));
            end
        end
        if (rd_log.size() == 4) begin
            for (int i = 1; i < 4; i++) check("t5_rd_period", rd_log[i], rd_log[0] + 32'(4*i));
        end

        // 6: reset mid-word discards the rest
        start_test();
        push(32'hA3A2A1A0, 4'hF, 1'b0, 1'b0);
        push(32'hB3B2B1B0, 4'hF, 1'b0, 1'b0);
        cycle();
        cycle();
        cycle();
        ARESETN = 1'b0;
        cycle();
        ARESETN = 1'b1;
        #1;
        check("t6_valid", 32'(pix_valid), 32'd0);
        check("t6_drop", 32'(drop_cnt), 32'd0);
        run_idle(20);
        check("t6_count", 32'(acc_log.size()), 32'd6);
        if (acc_log.size() == 6) begin
            check("t6_d1", 32'(acc_log[1].p.data), 32'hA1);
            check("t6_d2", 32'(acc_log[2].p.data), 32'hB0);
            check("t6_x2", 32'(acc_log[2].p.x), 32'd0);
            check("t6_d5", 32'(acc_log[5].p.data), 32'hB3);
            check("t6_x5", 32'(acc_log[5].p.x), 32'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
